// File: rtl/board_ctrl.sv
// Tic-tac-toe style board controller: cursor movement, mark placement, and a
// multi-cycle line scan around the last placed cell to detect wins and draws.
module board_ctrl #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3,
  localparam int AW     = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          btnCpuReset,
  input  logic          btnC,
  input  logic          btnU,
  input  logic          btnD,
  input  logic          btnL,
  input  logic          btnR,
  input  logic [AW-1:0] vga_addr,
  output logic [1:0]    vga_data,
  output logic [AW-1:0] cursor_addr,
  output logic          turn,
  output logic [1:0]    gameover,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(WIN_LEN + 1);
  localparam int DW = $clog2(2 * WIN_LEN);
  localparam int MW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cells_q [N];
  logic [1:0]    cells_d [N];
  logic [RW-1:0] row_q, row_d, piv_row_q, piv_row_d;
  logic [CW-1:0] col_q, col_d, piv_col_q, piv_col_d;
  logic          turn_q, turn_d;
  logic [1:0]    over_q, over_d;
  logic [MW-1:0] moves_q, moves_d;
  logic [1:0]    vga_q, vga_d;
  logic [1:0]    dir_q, dir_d;
  logic          side_q, side_d;
  logic [KW-1:0] k_q, k_d;
  logic          alive_q, alive_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          win_q, win_d;

  logic [AW-1:0] cur_idx, scan_idx;
  logic [1:0]    code, scan_cell;
  logic [DW-1:0] cnt_next;
  logic          on_board, hit, last_k;
  int            dr, dc, tr, tc;

  assign cur_idx     = AW'(int'(row_q) * COLS + int'(col_q));
  assign code        = turn_q ? 2'b10 : 2'b01;
  assign cursor_addr = cur_idx;
  assign turn        = turn_q;
  assign gameover    = over_q;
  assign busy        = (state_q != S_IDLE);
  assign vga_data    = vga_q;
  assign dbg_state   = state_q;

  // Cell probed this SCAN cycle: pivot + k * direction, negated on the second side.
  always_comb begin
    dr = 0;
    dc = 1;
    case (dir_q)
      2'd0:    begin dr = 0;  dc = 1; end
      2'd1:    begin dr = 1;  dc = 0; end
      2'd2:    begin dr = 1;  dc = 1; end
      default: begin dr = -1; dc = 1; end
    endcase
    if (side_q) begin
      dr = -dr;
      dc = -dc;
    end
    tr        = int'(piv_row_q) + dr * int'(k_q);
    tc        = int'(piv_col_q) + dc * int'(k_q);
    on_board  = (tr >= 0) && (tr < ROWS) && (tc >= 0) && (tc < COLS);
    scan_idx  = AW'(tr * COLS + tc);
    scan_cell = on_board ? cells_q[scan_idx] : 2'b00;
    hit       = alive_q && on_board && (scan_cell == code);
    cnt_next  = dcnt_q + DW'(hit);
    last_k    = (k_q == KW'(WIN_LEN - 1));
  end

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    row_d     = row_q;
    col_d     = col_q;
    piv_row_d = piv_row_q;
    piv_col_d = piv_col_q;
    turn_d    = turn_q;
    over_d    = over_q;
    moves_d   = moves_q;
    dir_d     = dir_q;
    side_d    = side_q;
    k_d       = k_q;
    alive_d   = alive_q;
    dcnt_d    = dcnt_q;
    win_d     = win_q;
    vga_d     = (int'(vga_addr) < N) ? cells_q[vga_addr] : 2'b00;

    case (state_q)
      S_IDLE: begin
        if (btnC) begin
          if (cells_q[cur_idx] == 2'b00) begin
            cells_d[cur_idx] = code;
            moves_d   = moves_q + MW'(1);
            piv_row_d = row_q;
            piv_col_d = col_q;
            dir_d     = 2'd0;
            side_d    = 1'b0;
            k_d       = KW'(1);
            alive_d   = 1'b1;
            dcnt_d    = '0;
            win_d     = 1'b0;
            state_d   = S_SCAN;
          end
        end else if (btnU) begin
          row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
        end else if (btnD) begin
          row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end else if (btnL) begin
          col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
        end else if (btnR) begin
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        end
      end
      S_SCAN: begin
        if (last_k && side_q) begin
          if (int'(cnt_next) + 1 >= WIN_LEN) win_d = 1'b1;
          dcnt_d  = '0;
          alive_d = 1'b1;
          side_d  = 1'b0;
          k_d     = KW'(1);
          if (dir_q == 2'd3) state_d = S_EVAL;
          else               dir_d   = dir_q + 2'd1;
        end else if (last_k) begin
          side_d  = 1'b1;
          k_d     = KW'(1);
          alive_d = 1'b1;
          dcnt_d  = cnt_next;
        end else begin
          k_d     = k_q + KW'(1);
          alive_d = hit;
          dcnt_d  = cnt_next;
        end
      end
      S_EVAL: begin
        if (win_q) begin
          over_d  = code;
          state_d = S_OVER;
        end else if (moves_q == MW'(N)) begin
          over_d  = 2'b11;
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (btnC) begin
          for (int i = 0; i < N; i++) cells_d[i] = 2'b00;
          moves_d = '0;
          over_d  = 2'b00;
          turn_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < N; i++) cells_q[i] <= 2'b00;
      row_q     <= '0;
      col_q     <= '0;
      piv_row_q <= '0;
      piv_col_q <= '0;
      turn_q    <= 1'b0;
      over_q    <= 2'b00;
      moves_q   <= '0;
      vga_q     <= 2'b00;
      dir_q     <= 2'd0;
      side_q    <= 1'b0;
      k_q       <= KW'(1);
      alive_q   <= 1'b1;
      dcnt_q    <= '0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      row_q     <= row_d;
      col_q     <= col_d;
      piv_row_q <= piv_row_d;
      piv_col_q <= piv_col_d;
      turn_q    <= turn_d;
      over_q    <= over_d;
      moves_q   <= moves_d;
      vga_q     <= vga_d;
      dir_q     <= dir_d;
      side_q    <= side_d;
      k_q       <= k_d;
      alive_q   <= alive_d;
      dcnt_q    <= dcnt_d;
      win_q     <= win_d;
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl on the default 3x3 board, three in a row to win.
module tb_board_ctrl;

  localparam int R = 3;
  localparam int C = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnC, btnU, btnD, btnL, btnR;
  logic [3:0] vga_addr;
  logic [1:0] vga_data;
  logic [3:0] cursor_addr;
  logic       turn;
  logic [1:0] gameover;
  logic       busy;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int m_r         = 0;
  int m_c         = 0;

  board_ctrl dut (
    .clk         (clk),
    .btnCpuReset (rst_n),
    .btnC        (btnC),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnL        (btnL),
    .btnR        (btnR),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .cursor_addr (cursor_addr),
    .turn        (turn),
    .gameover    (gameover),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Button vector order: {C, U, D, L, R}; one-cycle pulse straddling a rising edge.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btnC, btnU, btnD, btnL, btnR} = b;
    @(negedge clk);
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_r = 0;
    m_c = 0;
  endtask

  task automatic read_cell(input int idx, output logic [1:0] d);
    @(negedge clk);
    vga_addr = 4'(idx);
    @(negedge clk);
    d = vga_data;
  endtask

  // Walks the cursor to idx using the bench's own cursor model, then places and
  // waits out the 16-cycle scan plus the evaluate cycle.
  task automatic place(input int idx);
    while (m_r != idx / C) begin
      press(5'b00100);
      m_r = (m_r + 1) % R;
    end
    while (m_c != idx % C) begin
      press(5'b00001);
      m_c = (m_c + 1) % C;
    end
    vectors++;
    if (cursor_addr !== 4'(idx)) begin
      miscompares++;
      $display("FAIL place_cursor: got %0d expected %0d", cursor_addr, idx);
    end
    press(5'b10000);
    repeat (17) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {btnC, btnU, btnD, btnL, btnR} = 5'b11111;
    vga_addr = 4'd4;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cursor_addr, turn, gameover, busy, vga_data} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cur=%0d turn=%0b go=%b busy=%0b vga=%b expected all zero",
               cursor_addr, turn, gameover, busy, vga_data);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
  endtask

  task automatic test_cursor_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    btnL  = 1'b1;
    @(negedge clk);
    btnL = 1'b0;
    vectors++;
    if (cursor_addr !== 4'd2) begin
      miscompares++;
      $display("FAIL wrap_left_first_edge: got %0d expected 2", cursor_addr);
    end
    press(5'b01000);
    vectors++;
    if (cursor_addr !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_up: got %0d expected 8", cursor_addr);
    end
    press(5'b00001);
    vectors++;
    if (cursor_addr !== 4'd6) begin
      miscompares++;
      $display("FAIL wrap_right: got %0d expected 6", cursor_addr);
    end
    press(5'b00110);
    vectors++;
    if (cursor_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL priority_down_over_left: got %0d expected 0", cursor_addr);
    end
  endtask

  task automatic test_place_timing();
    int n;
    logic [1:0] d;
    do_reset();
    press(5'b00100);
    press(5'b00001);
    m_r = 1;
    m_c = 1;
    press(5'b10000);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 17) begin
      miscompares++;
      $display("FAIL busy_cycles: got %0d expected 17", n);
    end
    vectors++;
    if ({busy, turn, gameover} !== 4'b0100) begin
      miscompares++;
      $display("FAIL after_place: got busy=%0b turn=%0b go=%b expected busy=0 turn=1 go=00",
               busy, turn, gameover);
    end
    read_cell(4, d);
    vectors++;
    if (d !== 2'b01) begin
      miscompares++;
      $display("FAIL cell4_p1: got %b expected 01", d);
    end
  endtask

  task automatic test_row_win();
    do_reset();
    place(0);
    place(3);
    place(1);
    place(4);
    vectors++;
    if ({gameover, turn, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL prewin: got go=%b turn=%0b busy=%0b expected 00 0 0", gameover, turn, busy);
    end
    place(2);
    vectors++;
    if ({gameover, turn} !== 3'b010) begin
      miscompares++;
      $display("FAIL row_win: got go=%b turn=%0b expected go=01 turn=0", gameover, turn);
    end
    vectors++;
    if (busy !== 1'b1 || dbg_state !== 2'd3) begin
      miscompares++;
      $display("FAIL over_state: got busy=%0b state=%0d expected 1 3", busy, dbg_state);
    end
    press(5'b01000);
    vectors++;
    if (cursor_addr !== 4'd2) begin
      miscompares++;
      $display("FAIL over_move_ignored: got %0d expected 2", cursor_addr);
    end
  endtask

  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    logic [1:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) place(seq[i]);
    vectors++;
    if (gameover !== 2'b00 || turn !== 1'b0) begin
      miscompares++;
      $display("FAIL draw_pre: got go=%b turn=%0b expected 00 0", gameover, turn);
    end
    place(seq[8]);
    vectors++;
    if (gameover !== 2'b11) begin
      miscompares++;
      $display("FAIL draw: got go=%b expected 11", gameover);
    end
    press(5'b10000);
    m_r = 0;
    m_c = 0;
    vectors++;
    if ({gameover, turn, busy, cursor_addr} !== 8'b0) begin
      miscompares++;
      $display("FAIL restart: got go=%b turn=%0b busy=%0b cur=%0d expected all zero",
               gameover, turn, busy, cursor_addr);
    end
    for (int i = 0; i < 9; i++) begin
      read_cell(i, d);
      vectors++;
      if (d !== 2'b00) begin
        miscompares++;
        $display("FAIL restart_cell%0d: got %b expected 00", i, d);
      end
    end
  endtask

  task automatic test_ignored_dropped();
    logic [1:0] d;
    do_reset();
    place(4);
    press(5'b10000);
    vectors++;
    if (busy !== 1'b0 || turn !== 1'b1) begin
      miscompares++;
      $display("FAIL occupied_ignored: got busy=%0b turn=%0b expected 0 1", busy, turn);
    end
    press(5'b01000);
    press(5'b00010);
    m_r = 0;
    m_c = 0;
    press(5'b10000);
    repeat (2) @(negedge clk);
    btnR = 1'b1;
    @(negedge clk);
    btnR = 1'b0;
    repeat (14) @(negedge clk);
    vectors++;
    if ({busy, cursor_addr, turn} !== 6'b0) begin
      miscompares++;
      $display("FAIL scan_drop: got busy=%0b cur=%0d turn=%0b expected 0 0 0", busy, cursor_addr, turn);
    end
    read_cell(0, d);
    vectors++;
    if (d !== 2'b10) begin
      miscompares++;
      $display("FAIL cell0_p2: got %b expected 10", d);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] d;
    do_reset();
    vga_addr = 4'd4;
    press(5'b00100);
    press(5'b00001);
    press(5'b10000);
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_scan_busy: got %0b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, turn, gameover, cursor_addr, vga_data} !== 10'b0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%0b turn=%0b go=%b cur=%0d vga=%b expected all zero",
               busy, turn, gameover, cursor_addr, vga_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_r = 0;
    m_c = 0;
    read_cell(4, d);
    vectors++;
    if (d !== 2'b00) begin
      miscompares++;
      $display("FAIL aborted_cell4: got %b expected 00", d);
    end
    press(5'b00010);
    vectors++;
    if (cursor_addr !== 4'd2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort_idle: got cur=%0d busy=%0b expected 2 0", cursor_addr, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
    vga_addr = 4'd0;
    test_reset();
    test_cursor_wrap();
    test_place_timing();
    test_row_win();
    test_draw();
    test_ignored_dropped();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 3, board row count (2..16).
REQ-002 The block SHALL have parameter COLS, default 3, board column count (2..16).
REQ-003 The block SHALL have parameter WIN_LEN, default 3, marks in a line needed to win (2..min(ROWS,COLS)).
REQ-004 The block SHALL derive localparam AW = clog2(ROWS*COLS), the cell index width; cell index = row*COLS+col.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port btnCpuReset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports btnC, btnU, btnD, btnL, btnR, input, 1 each, debounced one-cycle button pulses.
REQ-008 The block SHALL have port vga_addr, input, AW, cell index for the display read port.
REQ-009 The block SHALL have port vga_data, output, 2, cell content at vga_addr, registered: 00 empty, 01 P1, 10 P2.
REQ-010 The block SHALL have port cursor_addr, output, AW, current cursor cell index.
REQ-011 The block SHALL have port turn, output, 1, player to move: 0 = P1, 1 = P2.
REQ-012 The block SHALL have port gameover, output, 2: 00 playing, 01 P1 won, 10 P2 won, 11 draw.
REQ-013 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SCAN, EVAL and OVER.
REQ-015 In IDLE, one accepted button per cycle SHALL be taken with priority btnC > btnU > btnD > btnL > btnR; all other simultaneous pulses are dropped.
REQ-016 btnU/btnD/btnL/btnR SHALL move the cursor by one row or column, wrapping at edges: row 0 up -> ROWS-1, col COLS-1 right -> 0.
REQ-017 btnC on an empty cell SHALL write the mover's code (01 or 10) at that edge, increment the move counter and enter SCAN.
REQ-018 btnC on an occupied cell SHALL be ignored, with no state, turn or busy change.
REQ-019 SCAN SHALL last exactly 8*(WIN_LEN-1) cycles, visiting directions E/W, S/N, SE/NW and NE/SW, each side k = 1..WIN_LEN-1, one cell per cycle.
REQ-020 During SCAN, a side's count SHALL stop at the first off-board cell or non-matching cell; later steps on that side add nothing.
REQ-021 EVAL SHALL last one cycle: a win exists if 1 + side counts >= WIN_LEN in any direction.
REQ-022 On a win, EVAL SHALL set gameover to the mover's code and go to OVER.
REQ-023 With no win and move count == ROWS*COLS, EVAL SHALL set gameover = 11 and go to OVER.
REQ-024 Otherwise EVAL SHALL toggle turn and return to IDLE.
REQ-025 Buttons pressed in SCAN or EVAL SHALL be discarded, not queued.
REQ-026 In OVER, only btnC SHALL act: in one cycle it clears all cells, the move counter and gameover, sets turn = 0 and cursor = 0, and enters IDLE.
REQ-027 Cursor movement in OVER SHALL be ignored.
REQ-028 vga_data SHALL reflect the cell at vga_addr sampled one edge earlier, independent of FSM state.
REQ-029 A cell written at edge N SHALL be visible on vga_data at edge N+1 or later.

Reset
REQ-030 While btnCpuReset is low, all cells = 00, cursor_addr = 0, turn = 0, gameover = 00, busy = 0, vga_data = 00, move counter = 0 and state = IDLE, asynchronously.
REQ-031 Reset asserted mid-SCAN or mid-EVAL SHALL abort the check with no partial result retained.
REQ-032 The first button SHALL be accepted on the first rising edge after btnCpuReset deasserts.

Verification (defaults 3x3, WIN_LEN=3)
REQ-033 The bench SHALL cover cursor wrap: after reset, btnL -> cursor_addr = 2; then btnU -> cursor_addr = 8; then btnR -> cursor_addr = 6.
REQ-034 The bench SHALL cover placement timing: btnC at cell 4 at edge E0 -> busy = 1 for 17 cycles, then busy = 0, turn = 1, vga_data(addr 4) = 01, gameover = 00.
REQ-035 The bench SHALL cover a P1 row win: moves P1 0, P2 3, P1 1, P2 4, P1 2 -> gameover = 01 after the final EVAL, turn stays 0, and later btnU leaves cursor_addr unchanged.
REQ-036 The bench SHALL cover a draw: moves at 0,1,2,4,3,5,7,6,8 alternating P1/P2 -> gameover = 11 after the 9th EVAL; then btnC -> all cells 00, gameover = 00, turn = 0.
REQ-037 The bench SHALL cover an ignored and dropped press: btnC on an occupied cell -> busy stays 0 and turn is unchanged; btnR pulsed during SCAN -> cursor unchanged.
REQ-038 The bench SHALL cover reset mid-SCAN: btnCpuReset low 2 cycles into SCAN -> all outputs at reset values and cell 00 at the placed index.
